tri_bus_arbiter: RTL and testbench
==================================

Name: tri_bus_arbiter

Overview:
- Round-robin arbiter that owns the select/enable side of the shared tri-state bus; sits directly upstream of tri_mux and its tri-state drivers.
- Converts per-source bus requests into a one-hot grant, matching one-hot output enables and a binary mux select.
- Inserts a mandatory turnaround gap of all-Z between owners, so at most one tri-state driver is ever enabled.

Parameters:
- N, 2, number of requesting sources; legal range 2..8.
- HOLD_MAX, 8, maximum consecutive grant cycles for one owner while another source is requesting; must be >= 1.
- TA_CYCLES, 1, turnaround cycles with all enables low between two owners; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- req  input  N  per-source bus request, level-sensitive.
- gnt  output  N  registered one-hot grant; all zero when no owner.
- oe  output  N  tri-state driver enables; always equal to gnt.
- sel  output  SW  binary index of current or last owner, where SW = $clog2(N); drives the tri_mux select.
- busy  output  1  high in GRANT and TURNAROUND states.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: gnt=0, oe=0, sel=0, busy=0, state=IDLE, rotating pointer ptr=0, hold_cnt=0, ta_cnt=0.
- Reset mid-operation: takes effect at the next clk edge from any state. The bus is released immediately and no turnaround is inserted.
- Arbitration function: selects the first set req bit at index ptr, ptr+1, ... wrapping modulo N.
- States:
  - IDLE: if any req is set, load the winner into gnt/oe/sel, clear hold_cnt, go to GRANT. Latency is 1 cycle: req seen at edge k gives gnt valid after edge k.
  - GRANT: hold_cnt increments and saturates at HOLD_MAX. The owner is released when either:
    - req[owner] is low, or
    - hold_cnt == HOLD_MAX-1 and some other req bit is high (preemption).
  - On release: gnt=0, oe=0, ptr=(owner+1) mod N, ta_cnt=0, go to TURNAROUND. sel holds the last owner.
  - GRANT with no competitor: the owner keeps the bus indefinitely with no gap.
  - TURNAROUND: all enables stay low for exactly TA_CYCLES cycles. On the last turnaround cycle, arbitrate as in IDLE: any req goes to GRANT, otherwise go to IDLE.
- Gap rule: the gap between two different owners is exactly TA_CYCLES cycles. The same source may re-win after the gap.
- Simultaneous events: owner drop and preemption in the same cycle are handled as one release. Requests arriving during TURNAROUND are considered only at its last cycle.
- Invariants:
  - popcount(oe) <= 1 always.
  - oe == gnt.
  - sel < N.
  - busy == (state != IDLE).
- Width rules:
  - hold_cnt width is $clog2(HOLD_MAX+1); ta_cnt width is $clog2(TA_CYCLES+1).
  - ptr wraps from N-1 to 0.

Optional Feature:
- Macro: TRI_BUS_ARB_LOCK_EN.
- Defined: adds input port lock (1 bit). While lock=1 and req[owner]=1, HOLD_MAX preemption is suppressed and hold_cnt stays saturated. Dropping lock re-enables preemption on the next cycle if hold_cnt has reached HOLD_MAX-1.
- Undefined: no lock port; preemption always applies.

Test Plan (N=2, HOLD_MAX=4, TA_CYCLES=1):
- Reset: rst_n=0 for 2 cycles with req=2'b11 -> gnt=00, oe=00, sel=0, busy=0 throughout.
- Single owner: req=01 at cycle 0, dropped at cycle 3 -> gnt=01 cycles 1-3; gnt=00 with busy=1 at cycle 4; busy=0 at cycle 5.
- Contention: req=11 held from cycle 0 -> gnt=01 cycles 1-4; gap gnt=00 at cycle 5; gnt=10 with sel=1 from cycle 6; alternation continues, oe never 11.
- No competitor: req=10 held for 12 cycles -> gnt=10 continuously from cycle 1, with no turnaround.
- Mid-op reset: rst_n=0 for one cycle while gnt=10 -> gnt=00 and sel=0 at next edge; then req=11 -> gnt=01 (ptr restored to 0).
- Lock (macro defined): lock=1, req=11 -> gnt=01 held for 10 cycles; lock=0 -> release the next cycle, then a 1-cycle gap, then gnt=10.

Source files
------------

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner selection for the shared tri-state bus: one-hot grant/enables, binary mux select,
// and an all-Z turnaround gap between owners. Define TRI_BUS_ARB_LOCK_EN to add the lock input.
module tri_bus_arbiter #(
  parameter int N         = 2,
  parameter int HOLD_MAX  = 8,
  parameter int TA_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef TRI_BUS_ARB_LOCK_EN
  input  logic                 lock,
`endif
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         oe,
  output logic [$clog2(N)-1:0] sel,
  output logic                 busy
);

  localparam int SW = $clog2(N);
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int TW = $clog2(TA_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MAX);
  localparam logic [TW-1:0] TA_LAST   = TW'(TA_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [N-1:0]    gnt_r, gnt_s;
  logic [SW-1:0]   sel_r, sel_s;
  logic [SW-1:0]   ptr_r, ptr_s;
  logic [HW-1:0]   hold_r, hold_s;
  logic [TW-1:0]   ta_r, ta_s;
  logic            busy_r, busy_s;
  logic [SW:0]     win_s;
  logic            found_s;
  logic [SW-1:0]   widx_s;
  logic            owner_req_s;
  logic            others_s;
  logic            lock_hold_s;
  logic            preempt_s;

  // First requester at or after p, wrapping modulo N; MSB flags that one was found.
  function automatic logic [SW:0] rr_pick(input logic [N-1:0] r, input logic [SW-1:0] p);
    logic          found;
    logic [SW-1:0] idx;
    logic [SW-1:0] j_v;
    found = 1'b0;
    idx   = {SW{1'b0}};
    for (int i = 0; i < N; i++) begin
      j_v = SW'((int'(p) + i) % N);
      if (!found && r[j_v]) begin
        found = 1'b1;
        idx   = j_v;
      end else begin
        idx   = idx;
      end
    end
    return {found, idx};
  endfunction

  // Successor index for the rotating priority pointer.
  function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] o);
    if (o == SW'(N - 1)) begin
      return {SW{1'b0}};
    end else begin
      return o + SW'(1);
    end
  endfunction

  assign win_s       = rr_pick(req, ptr_r);
  assign found_s     = win_s[SW];
  assign widx_s      = win_s[SW-1:0];
  assign owner_req_s = req[sel_r];
  assign others_s    = |(req & ~gnt_r);

  // Lock only shields an owner that still wants the bus.
  always_comb begin
`ifdef TRI_BUS_ARB_LOCK_EN
    lock_hold_s = lock & owner_req_s;
`else
    lock_hold_s = 1'b0;
`endif
    preempt_s = others_s & (hold_r >= HOLD_LAST) & ~lock_hold_s;
  end

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    sel_s   = sel_r;
    ptr_s   = ptr_r;
    hold_s  = hold_r;
    ta_s    = ta_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          gnt_s   = {{(N-1){1'b0}}, 1'b1} << widx_s;
          sel_s   = widx_s;
          hold_s  = {HW{1'b0}};
          state_s = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!owner_req_s || preempt_s) begin
          // sel keeps the last owner so the mux stays parked during the gap
          gnt_s   = {N{1'b0}};
          ptr_s   = next_idx(sel_r);
          ta_s    = {TW{1'b0}};
          state_s = ST_TURN;
        end else if (hold_r != HOLD_SAT) begin
          hold_s  = hold_r + HW'(1);
        end else begin
          hold_s  = hold_r;
        end
      end
      ST_TURN: begin
        if (ta_r != TA_LAST) begin
          ta_s    = ta_r + TW'(1);
        end else if (found_s) begin
          gnt_s   = {{(N-1){1'b0}}, 1'b1} << widx_s;
          sel_s   = widx_s;
          hold_s  = {HW{1'b0}};
          state_s = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        gnt_s   = {N{1'b0}};
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; reset drops the bus at once without a gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      gnt_r   <= {N{1'b0}};
      sel_r   <= {SW{1'b0}};
      ptr_r   <= {SW{1'b0}};
      hold_r  <= {HW{1'b0}};
      ta_r    <= {TW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      sel_r   <= sel_s;
      ptr_r   <= ptr_s;
      hold_r  <= hold_s;
      ta_r    <= ta_s;
      busy_r  <= busy_s;
    end
  end

  assign gnt  = gnt_r;
  assign oe   = gnt_r;
  assign sel  = sel_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter (N=2, HOLD_MAX=4, TA_CYCLES=1); lock steps build with TRI_BUS_ARB_LOCK_EN.
module tb_tri_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] oe;
  logic [0:0] sel;
  logic       busy;
`ifdef TRI_BUS_ARB_LOCK_EN
  logic       lock;
`endif

  int n_cmp;
  int n_bad;

  tri_bus_arbiter #(.N(2), .HOLD_MAX(4), .TA_CYCLES(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef TRI_BUS_ARB_LOCK_EN
    .lock (lock),
`endif
    .req  (req),
    .gnt  (gnt),
    .oe   (oe),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] eg, input logic es, input logic eb);
    n_cmp++;
    assert (gnt === eg) else begin
      n_bad++;
      $error("FAIL %s gnt=%b expected=%b", tag, gnt, eg);
    end
    n_cmp++;
    assert (oe === eg) else begin
      n_bad++;
      $error("FAIL %s oe=%b expected=%b", tag, oe, eg);
    end
    n_cmp++;
    assert (sel === es) else begin
      n_bad++;
      $error("FAIL %s sel=%b expected=%b", tag, sel, es);
    end
    n_cmp++;
    assert (busy === eb) else begin
      n_bad++;
      $error("FAIL %s busy=%b expected=%b", tag, busy, eb);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = 2'b11;
`ifdef TRI_BUS_ARB_LOCK_EN
    lock  = 1'b0;
`endif

    // Reset held two cycles with both requests up
    step(); chk("reset_c1", 2'b00, 1'b0, 1'b0);
    step(); chk("reset_c2", 2'b00, 1'b0, 1'b0);

    // Single owner: granted cycles 1-3, gap at 4, idle at 5
    rst_n = 1'b1;
    req   = 2'b01;
    step(); chk("single_c1", 2'b01, 1'b0, 1'b1);
    step(); chk("single_c2", 2'b01, 1'b0, 1'b1);
    step(); chk("single_c3", 2'b01, 1'b0, 1'b1);
    req = 2'b00;
    step(); chk("single_c4", 2'b00, 1'b0, 1'b1);
    step(); chk("single_c5", 2'b00, 1'b0, 1'b0);

    // Reset to return the pointer to 0
    rst_n = 1'b0;
    step(); chk("rst2", 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Contention: 4 cycles each, one-cycle gap, alternating
    req = 2'b11;
    for (int i = 1; i <= 4; i++) begin
      step(); chk($sformatf("contend_a_c%0d", i), 2'b01, 1'b0, 1'b1);
    end
    step(); chk("contend_gap1", 2'b00, 1'b0, 1'b1);
    for (int i = 6; i <= 9; i++) begin
      step(); chk($sformatf("contend_b_c%0d", i), 2'b10, 1'b1, 1'b1);
    end
    step(); chk("contend_gap2", 2'b00, 1'b1, 1'b1);
    step(); chk("contend_c11", 2'b01, 1'b0, 1'b1);
    req = 2'b00;
    step(); chk("contend_drop", 2'b00, 1'b0, 1'b1);
    step(); chk("contend_idle", 2'b00, 1'b0, 1'b0);

    // No competitor: source 1 keeps the bus with no gap (pointer is now 1)
    req = 2'b10;
    for (int i = 1; i <= 12; i++) begin
      step(); chk($sformatf("solo_c%0d", i), 2'b10, 1'b1, 1'b1);
    end

    // Mid-operation reset releases immediately; pointer back to 0
    rst_n = 1'b0;
    step(); chk("midrst", 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 2'b11;
    step(); chk("midrst_regrant", 2'b01, 1'b0, 1'b1);
    step(); chk("midrst_c2", 2'b01, 1'b0, 1'b1);
    step(); chk("midrst_c3", 2'b01, 1'b0, 1'b1);
    step(); chk("midrst_c4", 2'b01, 1'b0, 1'b1);
    step(); chk("midrst_gap", 2'b00, 1'b0, 1'b1);
    step(); chk("midrst_next", 2'b10, 1'b1, 1'b1);

`ifdef TRI_BUS_ARB_LOCK_EN
    // Lock suppresses preemption; dropping it releases on the next edge
    rst_n = 1'b0;
    req   = 2'b00;
    step(); chk("lock_rst", 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    lock  = 1'b1;
    req   = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      step(); chk($sformatf("lock_c%0d", i), 2'b01, 1'b0, 1'b1);
    end
    lock = 1'b0;
    step(); chk("lock_gap", 2'b00, 1'b0, 1'b1);
    step(); chk("lock_next", 2'b10, 1'b1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
